// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the cache refill path.
// Address layout: tag[31:12] / index[11:4] / word offset[3:0].
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 20;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;
  localparam int LINE_W   = ADDR_W - OFFSET_W;

  // Value of the beat counter while the final (16th) beat of a line is arriving.
  localparam logic [4:0] LAST_BEAT = 5'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: one miss -> one 16-beat line burst -> data-array writes -> tag/valid commit.
// CACHE_CRIT_WORD_FIRST_EN selects critical-word-first burst ordering; undefined gives line-aligned order.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                miss_ready,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rdata_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fill_we,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [OFFSET_W-1:0] fill_word,
  output logic [DATA_W-1:0]   fill_data,
  output logic                tag_we,
  output logic [INDEX_W-1:0]  tag_index,
  output logic [TAG_W-1:0]    tag_data,
  output logic                refill_done,
  output logic                busy
);

  refill_state_t       state_reg;
  logic [LINE_W-1:0]   line_reg;
  logic [OFFSET_W-1:0] ptr_reg;
  logic [4:0]          beats_reg;
  logic                miss_ready_reg;
  logic                mem_req_valid_reg;
  logic                tag_we_reg;
  logic                refill_done_reg;
  logic                busy_reg;
  logic [OFFSET_W-1:0] start_word;
  logic [ADDR_W-1:0]   line_addr;

`ifdef CACHE_CRIT_WORD_FIRST_EN
  assign start_word = addr_offset(miss_addr);
`else
  // Line-aligned bursts never look at the requested word.
  logic unused_offset;
  assign unused_offset = ^addr_offset(miss_addr);
  assign start_word    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      line_reg          <= '0;
      ptr_reg           <= '0;
      beats_reg         <= '0;
      miss_ready_reg    <= 1'b1;
      mem_req_valid_reg <= 1'b0;
      tag_we_reg        <= 1'b0;
      refill_done_reg   <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss_valid) begin
            line_reg          <= miss_addr[ADDR_W-1:OFFSET_W];
            ptr_reg           <= start_word;
            beats_reg         <= '0;
            state_reg         <= REQ;
            miss_ready_reg    <= 1'b0;
            mem_req_valid_reg <= 1'b1;
            busy_reg          <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_reg         <= FILL;
            mem_req_valid_reg <= 1'b0;
          end
        end
        FILL: begin
          // The beat count, not the wrapping word pointer, ends the burst.
          if (mem_rdata_valid) begin
            ptr_reg   <= ptr_reg + 4'd1;
            beats_reg <= beats_reg + 5'd1;
            if (beats_reg == LAST_BEAT) begin
              state_reg       <= COMMIT;
              tag_we_reg      <= 1'b1;
              refill_done_reg <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_reg       <= IDLE;
          tag_we_reg      <= 1'b0;
          refill_done_reg <= 1'b0;
          busy_reg        <= 1'b0;
          miss_ready_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The pointer holds the burst start word for the whole REQ phase.
  assign line_addr     = {line_reg, {OFFSET_W{1'b0}}};
  assign mem_req_addr  = {line_reg, ptr_reg};
  assign mem_req_valid = mem_req_valid_reg;
  assign miss_ready    = miss_ready_reg;
  assign busy          = busy_reg;

  assign fill_we    = (state_reg == FILL) && mem_rdata_valid;
  assign fill_index = addr_index(line_addr);
  assign fill_word  = ptr_reg;
  assign fill_data  = fill_we ? mem_rdata : '0;

  assign tag_we      = tag_we_reg;
  assign tag_index   = addr_index(line_addr);
  assign tag_data    = addr_tag(line_addr);
  assign refill_done = refill_done_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scenario bench for cache_refill_ctrl; expected burst order and addresses come from
// the address-field rules (critical-word-first when CACHE_CRIT_WORD_FIRST_EN is defined).
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [7:0]  fill_index;
  logic [3:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [7:0]  tag_index;
  logic [19:0] tag_data;
  logic        refill_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
    .tag_we(tag_we), .tag_index(tag_index), .tag_data(tag_data),
    .refill_done(refill_done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_req_addr(input logic [31:0] a);
`ifdef CACHE_CRIT_WORD_FIRST_EN
    return a;
`else
    return {a[31:4], 4'h0};
`endif
  endfunction

  function automatic logic [3:0] exp_first_word(input logic [31:0] a);
`ifdef CACHE_CRIT_WORD_FIRST_EN
    return a[3:0];
`else
    return 4'h0;
`endif
  endfunction

  task automatic start_miss(input logic [31:0] addr);
    miss_valid = 1'b1;
    miss_addr  = addr;
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept: miss_ready=%b required 1 (addr %h)", miss_ready, addr);
    end
    tick();
    miss_valid = 1'b0;
  endtask

  // Drives REQ, FILL and COMMIT for a miss already accepted; abort_beats>0 stops after that many beats.
  task automatic finish_refill(input logic [31:0] addr, input int req_wait, input int pct,
                               input int abort_beats, input bit hold, input logic [31:0] next_addr,
                               output int cycles);
    logic [3:0]  ew;
    logic [31:0] d;
    bit          v;
    int          beats;
    int          guard;
    cycles = 0;
    for (int c = 1; c <= req_wait; c++) begin
      mem_req_ready   = (c == req_wait);
      mem_rdata_valid = 1'($urandom_range(0, 1));
      mem_rdata       = $urandom;
      #1;
      cycles++;
      n_cmp++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_req_addr(addr) || fill_we !== 1'b0 ||
          miss_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL req_phase: req_valid=%b addr=%h fill_we=%b miss_ready=%b busy=%b required 1 %h 0 0 1",
                 mem_req_valid, mem_req_addr, fill_we, miss_ready, busy, exp_req_addr(addr));
      end
      tick();
    end
    mem_req_ready = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 16 && guard < 2000 && !(abort_beats != 0 && beats == abort_beats)) begin
      v = ($urandom_range(0, 99) < pct);
      d = $urandom;
      mem_rdata_valid = v;
      mem_rdata       = d;
      if (hold) begin
        miss_valid = 1'b1;
        miss_addr  = next_addr;
      end
      #1;
      cycles++;
      n_cmp++;
      if (fill_we !== v) begin
        n_err++;
        $display("FAIL fill_strobe: fill_we=%b required %b (beat %0d)", fill_we, v, beats);
      end
      if (v) begin
        ew = exp_first_word(addr) + 4'(beats);
        n_cmp++;
        if (fill_index !== addr[11:4] || fill_word !== ew || fill_data !== d) begin
          n_err++;
          $display("FAIL fill_write: index=%h word=%0d data=%h required %h %0d %h",
                   fill_index, fill_word, fill_data, addr[11:4], ew, d);
        end
        beats++;
      end
      n_cmp++;
      if (tag_we !== 1'b0 || refill_done !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b1 ||
          miss_ready !== 1'b0) begin
        n_err++;
        $display("FAIL fill_ctrl: tag_we=%b done=%b req_valid=%b busy=%b miss_ready=%b required 0 0 0 1 0",
                 tag_we, refill_done, mem_req_valid, busy, miss_ready);
      end
      tick();
      guard++;
    end
    mem_rdata_valid = 1'b0;
    if (abort_beats == 0) begin
      if (beats < 16) begin
        n_cmp++;
        n_err++;
        $display("FAIL fill_timeout: beats=%0d required 16", beats);
      end
      mem_rdata_valid = 1'b1;
      mem_rdata       = $urandom;
      #1;
      cycles++;
      n_cmp++;
      if (tag_we !== 1'b1 || refill_done !== 1'b1 || tag_index !== addr[11:4] ||
          tag_data !== addr[31:12] || fill_we !== 1'b0 || miss_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL commit: tag_we=%b done=%b idx=%h tag=%h fill_we=%b ready=%b busy=%b required 1 1 %h %h 0 0 1",
                 tag_we, refill_done, tag_index, tag_data, fill_we, miss_ready, busy, addr[11:4], addr[31:12]);
      end
      tick();
      mem_rdata_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b busy=%b req_valid=%b req_addr=%h required 1 0 0 0",
               miss_ready, busy, mem_req_valid, mem_req_addr);
    end
    n_cmp++;
    if (fill_we !== 1'b0 || fill_index !== 8'h0 || fill_word !== 4'h0 || fill_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_fill: we=%b idx=%h word=%h data=%h required all 0",
               fill_we, fill_index, fill_word, fill_data);
    end
    n_cmp++;
    if (tag_we !== 1'b0 || tag_index !== 8'h0 || tag_data !== 20'h0 || refill_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tag: we=%b idx=%h tag=%h done=%b required all 0",
               tag_we, tag_index, tag_data, refill_done);
    end
    rst = 1'b0;
    mem_rdata_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] a;
    int          cyc;
    a = $urandom;
    start_miss(a);
    finish_refill(a, 2, 100, 7, 1'b0, 32'h0, cyc);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = $urandom;
      #1;
      n_cmp++;
      if (tag_we !== 1'b0 || refill_done !== 1'b0 || (i > 0 && (busy !== 1'b0 || miss_ready !== 1'b1))) begin
        n_err++;
        $display("FAIL reset_abort: cycle %0d tag_we=%b done=%b busy=%b ready=%b", i, tag_we, refill_done,
                 busy, miss_ready);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || fill_we !== 1'b0 || tag_we !== 1'b0 ||
        refill_done !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after: ready=%b busy=%b fill_we=%b tag_we=%b done=%b req_valid=%b required 1 0 0 0 0 0",
               miss_ready, busy, fill_we, tag_we, refill_done, mem_req_valid);
    end
    mem_rdata_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    start_miss(32'h0001_2340);
    finish_refill(32'h0001_2340, 4, 100, 0, 1'b0, 32'h0, cyc);
    n_cmp++;
    if (cyc !== 21) begin
      n_err++;
      $display("FAIL basic_latency: cycles=%0d required 21", cyc);
    end
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || tag_we !== 1'b0 || refill_done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle: ready=%b busy=%b tag_we=%b done=%b required 1 0 0 0",
               miss_ready, busy, tag_we, refill_done);
    end
  endtask

  task automatic test_gaps();
    int cyc;
    start_miss(32'h0001_2340);
    finish_refill(32'h0001_2340, 1, 40, 0, 1'b0, 32'h0, cyc);
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1 || refill_done !== 1'b0) begin
      n_err++;
      $display("FAIL gaps_idle: ready=%b done=%b required 1 0", miss_ready, refill_done);
    end
  endtask

  task automatic test_idle_beats();
    for (int i = 0; i < 4; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = $urandom;
      #1;
      n_cmp++;
      if (fill_we !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_beat: fill_we=%b busy=%b required 0 0", fill_we, busy);
      end
      tick();
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_crit_word();
    int cyc;
    start_miss(32'h0000_0ABC);
    finish_refill(32'h0000_0ABC, 1, 100, 0, 1'b0, 32'h0, cyc);
    n_cmp++;
    if (cyc !== 18) begin
      n_err++;
      $display("FAIL min_latency: cycles=%0d required 18", cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    a = $urandom;
    b = $urandom;
    start_miss(a);
    finish_refill(a, 2, 70, 0, 1'b1, b, cyc);
    #1;
    n_cmp++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: ready=%b busy=%b req_valid=%b required 1 0 0", miss_ready, busy, mem_req_valid);
    end
    tick();
    miss_valid = 1'b0;
    finish_refill(b, 1, 100, 0, 1'b0, 32'h0, cyc);
    n_cmp++;
    if (cyc !== 18) begin
      n_err++;
      $display("FAIL b2b_latency: cycles=%0d required 18", cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          cyc;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      start_miss(a);
      finish_refill(a, $urandom_range(1, 5), $urandom_range(30, 100), 0, 1'b0, 32'h0, cyc);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0;
    miss_addr = 32'h0;
    mem_req_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_reset_mid_fill();
    test_basic();
    test_gaps();
    test_idle_beats();
    test_crit_word();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
